// File: rtl/dmem_responder.sv
// dmem_responder: a 32 x 32-bit data memory shared between a processor port
// and a host port. The enable input picks the owner, and a one-cycle
// turnaround state separates processor ownership from host ownership.
// Per-port access counters saturate instead of wrapping.
module dmem_responder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic [4:0]       dmem_addr,
    input  logic [31:0]      dmem_wdata,
    output logic [31:0]      dmem_rdata,
    input  logic             host_valid,
    input  logic             host_we,
    input  logic [4:0]       host_addr,
    input  logic [31:0]      host_wdata,
    output logic             host_ready,
    output logic             host_rvalid,
    output logic [31:0]      host_rdata,
    output logic [CNT_W-1:0] proc_rd_cnt,
    output logic [CNT_W-1:0] proc_wr_cnt
);

    // IDLE: host owns the memory
    // PROC: processor owns it
    // TURN: dead cycle before the host regains it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       mem_q [32];
    logic [31:0]       hostRdata_q;
    logic              hostRvalid_q;
    logic [CNT_W-1:0]  rdCnt_q;
    logic [CNT_W-1:0]  rdCnt_d;
    logic [CNT_W-1:0]  wrCnt_q;
    logic [CNT_W-1:0]  wrCnt_d;

    logic procRead;
    logic procWrite;
    logic hostAccept;
    logic hostRead;
    logic hostWrite;

    // Processor strobes only count while the processor owns the memory.
    // The host is accepted only in IDLE with enable low, so the two ports never collide.
    always_comb begin
        procRead   = enable && dmem_read;
        procWrite  = enable && dmem_write;
        host_ready = (state_q == IDLE) && !enable;
        hostAccept = host_valid && host_ready;
        hostRead   = hostAccept && !host_we;
        hostWrite  = hostAccept && host_we;
    end

    // Ownership FSM next-state logic; enable high always wins back the processor.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = PROC;
            PROC:    if (!enable) state_d = TURN;
            TURN:    state_d = enable ? PROC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ownership FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage array: reset clears every word; the processor write and the
    // host write are mutually exclusive through enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else if (procWrite) begin
            mem_q[dmem_addr] <= dmem_wdata;
        end else if (hostWrite) begin
            mem_q[host_addr] <= host_wdata;
        end
    end

    // Processor read path is combinational and shows the pre-write word on a read+write cycle.
    always_comb begin
        dmem_rdata = procRead ? mem_q[dmem_addr] : 32'd0;
    end

    // Host read data is captured at acceptance and held. The valid pulse lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hostRdata_q  <= '0;
            hostRvalid_q <= 1'b0;
        end else begin
            hostRvalid_q <= hostRead;
            if (hostRead) begin
                hostRdata_q <= mem_q[host_addr];
            end
        end
    end

    // Saturating next values for the processor access counters.
    always_comb begin
        rdCnt_d = rdCnt_q;
        wrCnt_d = wrCnt_q;
        if (procRead && (rdCnt_q != {CNT_W{1'b1}})) begin
            rdCnt_d = rdCnt_q + CNT_W'(1);
        end
        if (procWrite && (wrCnt_q != {CNT_W{1'b1}})) begin
            wrCnt_d = wrCnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdCnt_q <= '0;
            wrCnt_q <= '0;
        end else begin
            rdCnt_q <= rdCnt_d;
            wrCnt_q <= wrCnt_d;
        end
    end

    assign host_rvalid = hostRvalid_q;
    assign host_rdata  = hostRdata_q;
    assign proc_rd_cnt = rdCnt_q;
    assign proc_wr_cnt = wrCnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder. Drives directed vectors into two instances
// (default counter width and a 2-bit counter width). Both instances are
// compared every cycle against a behavioural model, and hand-computed
// literal checks pin the key scenarios.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        dmem_read;
    logic        dmem_write;
    logic [4:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        host_valid;
    logic        host_we;
    logic [4:0]  host_addr;
    logic [31:0] host_wdata;

    logic [31:0] dmem_rdata;
    logic        host_ready;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [15:0] proc_rd_cnt;
    logic [15:0] proc_wr_cnt;

    logic [31:0] dmemRdataB;
    logic        hostReadyB;
    logic        hostRvalidB;
    logic [31:0] hostRdataB;
    logic [1:0]  procRdCntB;
    logic [1:0]  procWrCntB;

    int testsRun = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Behavioural model state
    logic [31:0] mMem [32];
    logic [31:0] mRdata;
    bit          mRvalid;
    int          mRd;
    int          mWr;
    int          mRdB;
    int          mWrB;
    bit          enHist1;
    bit          enHist2;

    dmem_responder #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .proc_rd_cnt(proc_rd_cnt), .proc_wr_cnt(proc_wr_cnt)
    );

    dmem_responder #(.CNT_W(2)) dutB (
        .clk(clk), .reset(reset), .enable(enable),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmemRdataB),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(hostReadyB),
        .host_rvalid(hostRvalidB), .host_rdata(hostRdataB),
        .proc_rd_cnt(procRdCntB), .proc_wr_cnt(procWrCntB)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit rd, input bit wr,
                                 input logic [4:0] daddr, input logic [31:0] dwdata,
                                 input bit hv, input bit hwe,
                                 input logic [4:0] haddr, input logic [31:0] hwdata);
        enable     = en;
        dmem_read  = rd;
        dmem_write = wr;
        dmem_addr  = daddr;
        dmem_wdata = dwdata;
        host_valid = hv;
        host_we    = hwe;
        host_addr  = haddr;
        host_wdata = hwdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // The host may access only if enable is low now and was low at the last two edges.
    // Any recent high enable means the processor or the turnaround still holds the memory.
    function automatic bit expReady();
        return !enable && !enHist1 && !enHist2;
    endfunction

    // Behavioural model, updated on the same edges the design sees
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mMem[i] <= 32'd0;
            mRdata  <= 32'd0;
            mRvalid <= 1'b0;
            mRd     <= 0;
            mWr     <= 0;
            mRdB    <= 0;
            mWrB    <= 0;
            enHist1 <= 1'b0;
            enHist2 <= 1'b0;
        end else begin
            mRvalid <= host_valid && expReady() && !host_we;
            if (host_valid && expReady() && !host_we) mRdata <= mMem[host_addr];
            if (host_valid && expReady() && host_we) mMem[host_addr] <= host_wdata;
            if (enable && dmem_write) mMem[dmem_addr] <= dmem_wdata;
            if (enable && dmem_read) begin
                mRd  <= (mRd < 65535) ? mRd + 1 : mRd;
                mRdB <= (mRdB < 3) ? mRdB + 1 : mRdB;
            end
            if (enable && dmem_write) begin
                mWr  <= (mWr < 65535) ? mWr + 1 : mWr;
                mWrB <= (mWrB < 3) ? mWrB + 1 : mWrB;
            end
            enHist2 <= enHist1;
            enHist1 <= enable;
        end
    end

    // Compare every output of both instances against the model on each falling edge
    always @(negedge clk) begin
        logic [31:0] expRdata;
        if (checking) begin
            expRdata = (enable && dmem_read) ? mMem[dmem_addr] : 32'd0;
            checkOutput("dmem_rdata", dmem_rdata, expRdata);
            checkOutput("host_ready", 32'(host_ready), 32'(expReady()));
            checkOutput("host_rvalid", 32'(host_rvalid), 32'(mRvalid));
            checkOutput("host_rdata", host_rdata, mRdata);
            checkOutput("proc_rd_cnt", 32'(proc_rd_cnt), mRd);
            checkOutput("proc_wr_cnt", 32'(proc_wr_cnt), mWr);
            checkOutput("B dmem_rdata", dmemRdataB, expRdata);
            checkOutput("B host_ready", 32'(hostReadyB), 32'(expReady()));
            checkOutput("B host_rvalid", 32'(hostRvalidB), 32'(mRvalid));
            checkOutput("B host_rdata", hostRdataB, mRdata);
            checkOutput("B proc_rd_cnt", 32'(procRdCntB), mRdB);
            checkOutput("B proc_wr_cnt", 32'(procWrCntB), mWrB);
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        repeat (2) tick();
        checking = 1'b1;

        // Reset state
        checkOutput("reset dmem_rdata", dmem_rdata, 32'd0);
        checkOutput("reset host_ready", 32'(host_ready), 32'd1);
        checkOutput("reset host_rvalid", 32'(host_rvalid), 32'd0);
        checkOutput("reset host_rdata", host_rdata, 32'd0);
        checkOutput("reset proc_rd_cnt", 32'(proc_rd_cnt), 32'd0);
        checkOutput("reset proc_wr_cnt", 32'(proc_wr_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // Host load and readback
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 1, 5'd0, 32'd112);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 1, 5'd1, 32'd123);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd1, 32'd0);
        tick();
        checkOutput("host read rvalid", 32'(host_rvalid), 32'd1);
        checkOutput("host read rdata", host_rdata, 32'd123);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        checkOutput("rvalid one cycle", 32'(host_rvalid), 32'd0);
        checkOutput("rdata held", host_rdata, 32'd123);

        // Processor access
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("ready low with enable", 32'(host_ready), 32'd0);
        tick();
        applyStimulus(1, 1, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("proc read addr0", dmem_rdata, 32'd112);
        tick();
        applyStimulus(1, 1, 0, 5'd1, 32'd0, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("proc read addr1", dmem_rdata, 32'd123);
        tick();
        applyStimulus(1, 0, 1, 5'd2, 32'd235, 0, 0, 5'd0, 32'd0);
        tick();
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1;
        checkOutput("proc_rd_cnt after access", 32'(proc_rd_cnt), 32'd2);
        checkOutput("proc_wr_cnt after access", 32'(proc_wr_cnt), 32'd1);

        // Handback, including a host write offered during the turnaround
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 1, 5'd3, 32'd77);
        #1 checkOutput("ready low in turnaround", 32'(host_ready), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("ready high after turnaround", 32'(host_ready), 32'd1);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd2, 32'd0);
        tick();
        checkOutput("handback read addr2", host_rdata, 32'd235);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd3, 32'd0);
        tick();
        checkOutput("turnaround write ignored", host_rdata, 32'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();

        // Saturation: five reads push the 2-bit counter to its ceiling
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        applyStimulus(1, 1, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        repeat (5) tick();
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        #1;
        checkOutput("B proc_rd_cnt saturated", 32'(procRdCntB), 32'd3);
        checkOutput("proc_rd_cnt wide", 32'(proc_rd_cnt), 32'd7);

        // Read and write in the same cycle returns the old word
        applyStimulus(1, 1, 1, 5'd2, 32'hDEADBEEF, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("read-during-write old", dmem_rdata, 32'd235);
        tick();
        applyStimulus(1, 1, 0, 5'd2, 32'd0, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("read-during-write new", dmem_rdata, 32'hDEADBEEF);
        tick();

        // Processor strobes are ignored while enable is low
        applyStimulus(0, 1, 1, 5'd5, 32'h55, 0, 0, 5'd0, 32'd0);
        #1 checkOutput("rdata zero when disabled", dmem_rdata, 32'd0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd5, 32'd0);
        tick();
        checkOutput("disabled write ignored", host_rdata, 32'd0);
        checkOutput("rd_cnt frozen", 32'(proc_rd_cnt), 32'd9);
        checkOutput("wr_cnt frozen", 32'(proc_wr_cnt), 32'd2);
        checkOutput("B wr_cnt", 32'(procWrCntB), 32'd2);

        // Read accepted just before enable rises still delivers its data
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd1, 32'd0);
        tick();
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 1, 1, 5'd0, 32'd999);
        #1;
        checkOutput("rvalid across enable rise", 32'(host_rvalid), 32'd1);
        checkOutput("rdata across enable rise", host_rdata, 32'd123);
        tick();
        checkOutput("rvalid drops under enable", 32'(host_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
        tick();
        checkOutput("blocked host write ignored", host_rdata, 32'd112);

        // Reset in the cycle after a read is accepted
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd1, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset kills rvalid", 32'(host_rvalid), 32'd0);
        checkOutput("reset clears rdata", host_rdata, 32'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1, 0, 5'd0, 32'd0);
        tick();
        checkOutput("post-reset rvalid", 32'(host_rvalid), 32'd1);
        checkOutput("post-reset addr0", host_rdata, 32'd0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 32'd0);
        tick();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
